// File: rtl/load_store_unit.sv
// Load/store unit: runs a req/gnt/rvalid data-bus transaction per core access,
// steering byte lanes, extending load data and stalling the core meanwhile.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [2:0]  mem_width,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  width_q, width_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;

    logic        req_act;
    logic        mis;
    logic        timeout;
    logic [31:0] ld_ext;
    logic [3:0]  lane_strb;
    logic [31:0] lane_data;

    // Sign/zero extension of the selected byte or half of a bus read word
    function automatic logic [31:0] extend(input logic [31:0] d,
                                           input logic [1:0]  a,
                                           input logic [2:0]  w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        unique case (w[1:0])
            2'b00:   r = w[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = w[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request qualification, alignment check and timeout detection
    always_comb begin
        req_act = (mem_read | mem_write) & ~flush & ~rst;
        unique case (mem_width[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr[0];
            default: mis = |addr[1:0];
        endcase
        timeout = (cnt_q == TMO_LAST);
        ld_ext  = we_q ? 32'h0 : extend(bus_rdata, addr_q[1:0], width_q);
    end

    // Write lane steering from the captured request
    always_comb begin
        unique case (width_q[1:0])
            2'b00: begin
                lane_strb = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_strb = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_strb = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
    end

    // Next-state and control outputs of the transaction FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        width_d    = width_q;
        we_d       = we_q;
        ld_d       = ld_q;
        err_d      = err_q;
        cnt_d      = 8'd0;
        stall      = 1'b0;
        misaligned = 1'b0;
        done       = 1'b0;
        bus_req    = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (req_act) begin
                    if (mis) begin
                        misaligned = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = addr;
                        wdata_d = write_data;
                        width_d = mem_width;
                        we_d    = mem_write;
                        ld_d    = 32'h0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (bus_gnt && bus_rvalid) begin
                    ld_d    = ld_ext;
                    state_d = DONE;
                end else if (timeout) begin
                    ld_d    = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    ld_d    = ld_ext;
                    state_d = DONE;
                end else if (timeout) begin
                    ld_d    = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Bus-facing and result outputs are only live in their owning state
    always_comb begin
        bus_we    = (state_q == REQ) & we_q;
        bus_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
        bus_wstrb = (state_q == REQ && we_q) ? lane_strb : 4'b0000;
        bus_wdata = (state_q == REQ) ? lane_data : 32'h0;
        load_data = (state_q == DONE) ? ld_q : 32'h0;
        bus_err   = (state_q == DONE) & err_q;
    end

    // State and captured-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            width_q <= 3'b0;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
            ld_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: table of bus transactions plus
// hand-written reset, flush and spurious-response sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, flush;
    logic [31:0] addr, write_data;
    logic [2:0]  mem_width;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
        .addr(addr), .write_data(write_data), .mem_width(mem_width),
        .stall(stall), .load_data(load_data), .done(done),
        .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        int          gnt_at;
        int          rv_at;
        logic [31:0] rdata;
        logic        mis;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        int          lat;
        int          reqn;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  req_n, stall_n, done_at;
        bit  seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_read   = v.rd;
        mem_write  = v.wr;
        mem_width  = v.w;
        addr       = v.a;
        write_data = v.wd;
        flush      = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        #1;
        if (v.mis) begin
            chk({tag, "_mis"}, 32'(misaligned), 32'd1);
            chk({tag, "_mis_stall"}, 32'(stall), 32'd0);
            chk({tag, "_mis_req"}, 32'(bus_req), 32'd0);
            return;
        end
        chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
        chk({tag, "_acc_mis"}, 32'(misaligned), 32'd0);
        done_at = 0;
        req_n   = 0;
        stall_n = 1;
        seen    = 1'b0;
        for (int c = 1; c <= 12 && done_at == 0; c++) begin
            @(negedge clk);
            bus_gnt    = (c == v.gnt_at);
            bus_rvalid = (c == v.rv_at);
            bus_rdata  = (c == v.rv_at) ? v.rdata : 32'h0;
            #1;
            if (bus_req) begin
                req_n++;
                if (!seen) begin
                    seen = 1'b1;
                    chk({tag, "_addr"}, bus_addr, {v.a[31:2], 2'b00});
                    chk({tag, "_we"}, 32'(bus_we), 32'(v.we));
                    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(v.wstrb));
                    chk({tag, "_wdata"}, bus_wdata, v.wdata);
                end
            end
            if (stall) stall_n++;
            if (done) begin
                done_at = c;
                chk({tag, "_load"}, load_data, v.ld);
                chk({tag, "_err"}, 32'(bus_err), 32'(v.err));
            end
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk({tag, "_done_at"}, 32'(done_at), 32'(v.lat));
        chk({tag, "_stall_cyc"}, 32'(stall_n), 32'(v.lat));
        chk({tag, "_req_cyc"}, 32'(req_n), 32'(v.reqn));
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        flush      = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
    endtask

    vec_t vt[17];

    initial begin
        //        rd wr  w       a             wd            g  r  rdata        mis we strb     wdata         ld            err lat reqn
        vt[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        1, 3, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 4, 1};
        vt[1]  = '{1, 0, 3'b000, 32'h203, 32'h0,        1, 1, 32'h80FF1234, 0, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 2, 1};
        vt[2]  = '{1, 0, 3'b100, 32'h203, 32'h0,        1, 1, 32'h80FF1234, 0, 0, 4'b0000, 32'h0,        32'h00000080, 0, 2, 1};
        vt[3]  = '{0, 1, 3'b001, 32'h302, 32'h0000ABCD, 1, 1, 32'h0,        0, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 2, 1};
        vt[4]  = '{1, 0, 3'b010, 32'h101, 32'h0,        0, 0, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0};
        vt[5]  = '{0, 1, 3'b000, 32'h101, 32'h0000005A, 2, 2, 32'h0,        0, 1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0, 3, 2};
        vt[6]  = '{1, 0, 3'b010, 32'h500, 32'h0,        0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 5, 4};
        vt[7]  = '{1, 0, 3'b001, 32'h102, 32'h0,        1, 2, 32'h80017FFF, 0, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0, 3, 1};
        vt[8]  = '{1, 0, 3'b101, 32'h106, 32'h0,        1, 2, 32'h80017FFF, 0, 0, 4'b0000, 32'h0,        32'h00008001, 0, 3, 1};
        vt[9]  = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 0, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0};
        vt[10] = '{1, 0, 3'b011, 32'h102, 32'h0,        0, 0, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0};
        vt[11] = '{1, 1, 3'b010, 32'h400, 32'h12345678, 1, 1, 32'hFFFFFFFF, 0, 1, 4'b1111, 32'h12345678, 32'h0,        0, 2, 1};
        vt[12] = '{1, 0, 3'b000, 32'h201, 32'h0,        1, 1, 32'h00007F00, 0, 0, 4'b0000, 32'h0,        32'h0000007F, 0, 2, 1};
        vt[13] = '{1, 0, 3'b010, 32'h600, 32'h0,        1, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 5, 1};
        vt[14] = '{1, 0, 3'b010, 32'h604, 32'h0,        1, 4, 32'h11223344, 0, 0, 4'b0000, 32'h0,        32'h11223344, 0, 5, 1};
        vt[15] = '{0, 1, 3'b000, 32'h303, 32'h000000C3, 1, 1, 32'h0,        0, 1, 4'b1000, 32'hC3C3C3C3, 32'h0,        0, 2, 1};
        vt[16] = '{1, 0, 3'b110, 32'h700, 32'h0,        1, 1, 32'hCAFEF00D, 0, 0, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 2, 1};

        // Reset state with a pending request held on the inputs
        rst        = 1'b1;
        idle_inputs();
        mem_read   = 1'b1;
        mem_width  = 3'b010;
        addr       = 32'h100;
        write_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", {load_data[15:0], bus_addr[11:0], bus_wstrb},
            32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

        // Response arriving with nothing outstanding is ignored
        run_vec(100, vt[6]);
        @(negedge clk);
        idle_inputs();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFFFFFF;
        #1;
        chk("late_rv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        chk("late_rv_done", 32'(done), 32'd0);
        chk("late_rv_req", 32'(bus_req), 32'd0);

        // flush during REQ does not abort the access
        @(negedge clk);
        mem_read  = 1'b1;
        mem_width = 3'b010;
        addr      = 32'h800;
        @(negedge clk);
        flush      = 1'b1;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BADF00D;
        #1;
        chk("flush_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        #1;
        chk("flush_done", 32'(done), 32'd1);
        chk("flush_load", load_data, 32'h0BADF00D);
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset in WAIT kills the access immediately
        @(negedge clk);
        mem_read  = 1'b1;
        mem_width = 3'b010;
        addr      = 32'h100;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("wait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("arst_nodone", 32'(done), 32'd0);

        // Flushed request is not accepted
        @(negedge clk);
        mem_read = 1'b1;
        flush    = 1'b1;
        addr     = 32'h100;
        #1;
        chk("flush_nacc_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("flush_nacc_req", 32'(bus_req), 32'd0);
        chk("flush_nacc_stall2", 32'(stall), 32'd0);
        idle_inputs();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
